// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and default sizes for the register file slice.
//   clr_state_t  - bulk-clear sequencer states (IDLE, CLEAR, DONE)
//   DEF_DATA_W   - default word width
//   DEF_NUM_REGS - default register count
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;

endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: bulk-clear sequencer. Walks an index over every register,
// one per clock, and tells the storage which word to zero.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr_req    - clear request level, sampled only while idle
//   clr_busy   - high for every cycle the sequence is zeroing words
//   clr_done   - single-cycle pulse after the last word is zeroed
//   clr_we     - zero strobe for the storage array
//   clr_idx    - register being zeroed at the next edge
//   state      - current sequencer state, exported for observation
//
// Handshake: clr_req is a level sampled at a rising edge while idle; once
// taken, clr_busy rises for NUM_REGS cycles, then clr_done pulses for one
// cycle. Requests during busy or done are ignored, not queued.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx,
  output clr_state_t        state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] idx;

  // busy/done are registered alongside the state so they leave the block
  // straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            // Last word is zeroed on this edge; idx wraps rather than overruns.
            state    <= DONE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          idx      <= '0;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we  = (state == CLEAR);
  assign clr_idx = idx;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: flip-flop register file, one write port, two read ports,
// optional hardwired zero register, optional same-cycle write bypass and a
// sequenced bulk clear.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  - write port, commits at the rising edge
//   rd_en1/rd_addr1        - read port 1 select, rd_data1 combinational
//   rd_en2/rd_addr2        - read port 2 select, rd_data2 combinational
//   clr_req                - bulk clear request (level)
//   clr_busy, clr_done     - clear in progress / completion pulse
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  clr_state_t        clr_state;
  logic              clr_active;
  logic              user_we;

  reg_file_clr_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .state    (clr_state)
  );

  assign clr_active = (clr_state == CLEAR);

  // User writes are dropped while clearing and never touch the zero register.
  assign user_we = wr_en && !clr_we && !(ZERO_EN && (wr_addr == '0));

  // Priority: reset, then clear sequence, then user write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_we) begin
      regs[clr_idx] <= '0;
    end else if (user_we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_mux(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] d;
    d = stored;
    if (!en) begin
      d = '0;
    end else if (ZERO_EN && (addr == '0)) begin
      d = '0;
    end else if (clr_active) begin
      d = '0;
    end else if (BYPASS_EN && wr_en && (wr_addr == addr)) begin
      d = wr_data;
    end
    return d;
  endfunction

  assign rd_data1 = read_mux(rd_en1, rd_addr1, regs[rd_addr1]);
  assign rd_data2 = read_mux(rd_en2, rd_addr2, regs[rd_addr2]);

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: drives two register files side by side (default build
// with zero register and bypass, and a build with both disabled) from the same
// inputs, checks every cycle against a behavioural model, and pins the model
// with directed literal expectations.
module tb_reg_file_param;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en1, rd_en2;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          clr_req;

  logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic          busy_a, done_a, busy_b, done_b;

  reg_file_param #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd1_a),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd2_a),
    .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
  );

  reg_file_param #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd1_b),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd2_b),
    .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A clear is modelled as wiping everything at the accepting edge: the
  // sequenced zeroing is invisible because reads return 0 and writes drop
  // while busy, and the result afterwards is all-zero either way.
  logic [DW-1:0] mem_a [NR];
  logic [DW-1:0] mem_b [NR];
  int busy_left = 0;
  bit done_m = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NR; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        busy_left = 0;
        done_m = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) done_m = 1'b1;
      end else begin
        if (wr_en) begin
          if (wr_addr != 0) mem_a[wr_addr] = wr_data;
          mem_b[wr_addr] = wr_data;
        end
        if (done_m) begin
          done_m = 1'b0;
        end else if (clr_req) begin
          for (int i = 0; i < NR; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
          busy_left = NR;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input bit zero, input bit byp, input logic en,
                                           input logic [AW-1:0] a, input logic [DW-1:0] stored);
    if (!en) return '0;
    if (zero && a == 0) return '0;
    if (busy_left > 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return stored;
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (check_on) begin
        check("rd1_a", rd1_a, exp_rd(1'b1, 1'b1, rd_en1, rd_addr1, mem_a[rd_addr1]));
        check("rd2_a", rd2_a, exp_rd(1'b1, 1'b1, rd_en2, rd_addr2, mem_a[rd_addr2]));
        check("rd1_b", rd1_b, exp_rd(1'b0, 1'b0, rd_en1, rd_addr1, mem_b[rd_addr1]));
        check("rd2_b", rd2_b, exp_rd(1'b0, 1'b0, rd_en2, rd_addr2, mem_b[rd_addr2]));
        check("busy_a", {15'd0, busy_a}, {15'd0, busy_left > 0});
        check("done_a", {15'd0, done_a}, {15'd0, done_m});
        check("busy_b", {15'd0, busy_b}, {15'd0, busy_left > 0});
        check("done_b", {15'd0, done_b}, {15'd0, done_m});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // Runs a clear from request and counts busy/done cycles; optionally fires a
  // write in the middle of the sequence.
  task automatic run_clear(input bit mid_write, output int nb, output int nd, output int first_done);
    nb = 0; nd = 0; first_done = -1;
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a) nb++;
      if (done_a) begin
        nd++;
        if (first_done < 0) first_done = i;
      end
      cyc();
      wr_en = mid_write && (i == 4);
      wr_addr = 4'd7;
      wr_data = 16'h5555;
    end
    wr_en = 1'b0;
  endtask

  int nb, nd, fd;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en1 = 1'b0; rd_en2 = 1'b0; rd_addr1 = '0; rd_addr2 = '0; clr_req = 1'b0;
    cyc();
    check_on = 1'b1;
    cyc();
    rst = 1'b0;

    // Reset state: every address reads 0 on both ports.
    @(negedge clk);
    check("rst_busy", {15'd0, busy_a}, 16'd0);
    check("rst_done", {15'd0, done_a}, 16'd0);
    for (int a = 0; a < NR; a++) begin
      cyc();
      rd_en1 = 1'b1; rd_en2 = 1'b1;
      rd_addr1 = AW'(a); rd_addr2 = AW'(NR - 1 - a);
      @(negedge clk);
      check("rst_rd1", rd1_a, 16'h0000);
      check("rst_rd2", rd2_a, 16'h0000);
    end
    cyc();

    // Plain write then read on both ports.
    write(4'd5, 16'hBEEF);
    rd_addr1 = 4'd5; rd_addr2 = 4'd5;
    @(negedge clk);
    check("wr_rd1", rd1_a, 16'hBEEF);
    check("wr_rd2", rd2_a, 16'hBEEF);
    check("wr_rd1_b", rd1_b, 16'hBEEF);
    cyc();

    // Same-cycle bypass: forwarded with bypass, old value without.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; rd_addr1 = 4'd3;
    @(negedge clk);
    check("byp_on", rd1_a, 16'h1234);
    check("byp_off", rd1_b, 16'h0000);
    cyc();
    wr_en = 1'b0;

    // Zero register.
    write(4'd0, 16'hFFFF);
    rd_addr1 = 4'd0;
    @(negedge clk);
    check("zero_reg", rd1_a, 16'h0000);
    check("no_zero_reg", rd1_b, 16'hFFFF);
    cyc();

    // Fill r1..r15 and run a clear with a write dropped mid-sequence.
    for (int r = 1; r < NR; r++) write(AW'(r), 16'hA5A5);
    rd_addr1 = 4'd9;
    @(negedge clk);
    check("fill_rd", rd1_a, 16'hA5A5);
    cyc();
    run_clear(1'b1, nb, nd, fd);
    check("clr_busy_cycles", 16'(nb), 16'd16);
    check("clr_done_cycles", 16'(nd), 16'd1);
    check("clr_done_pos", 16'(fd), 16'd16);
    for (int a = 0; a < NR; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(a);
      @(negedge clk);
      check("post_clr_a", rd1_a, 16'h0000);
      check("post_clr_b", rd2_b, 16'h0000);
      cyc();
    end

    // Reset in the middle of a clear.
    write(4'd9, 16'h1357);
    write(4'd12, 16'h2468);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd_addr1 = 4'd9; rd_addr2 = 4'd12;
    @(negedge clk);
    check("rstmid_busy", {15'd0, busy_a}, 16'd0);
    check("rstmid_rd1", rd1_a, 16'h0000);
    check("rstmid_rd2", rd2_b, 16'h0000);
    cyc();
    run_clear(1'b0, nb, nd, fd);
    check("reclr_busy_cycles", 16'(nb), 16'd16);
    check("reclr_done_cycles", 16'(nd), 16'd1);

    // Randomized traffic against the model.
    repeat (3000) begin
      rst      = ($urandom_range(0, 299) == 0);
      clr_req  = ($urandom_range(0, 39) == 0);
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = AW'($urandom_range(0, NR - 1));
      wr_data  = DW'($urandom);
      rd_en1   = ($urandom_range(0, 3) != 0);
      rd_en2   = ($urandom_range(0, 3) != 0);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      cyc();
    end
    rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0;
    repeat (2) cyc();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
